// File: rtl/imm_ext_arbiter_pkg.sv
// Shared definitions for the immediate-extension arbiter: default widths,
// extension mode encodings and the controller state encoding.
package imm_ext_arbiter_pkg;

  localparam int DW_DEF = 16;
  localparam int FW_DEF = 12;

  localparam logic [1:0] MODE_SEXT8  = 2'b00;
  localparam logic [1:0] MODE_SEXT12 = 2'b01;
  localparam logic [1:0] MODE_ZPAD8  = 2'b10;
  localparam logic [1:0] MODE_ZPAD12 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXT  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/imm_ext_arbiter_if.sv
// Request/response bundle between the two requesters, the consumer and the
// shared extender. The slave modport is the arbiter side.
interface imm_ext_arbiter_if
  import imm_ext_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
);

  logic          req0_valid;
  logic          req0_ready;
  logic [FW-1:0] req0_field;
  logic [1:0]    req0_mode;
  logic          req1_valid;
  logic          req1_ready;
  logic [FW-1:0] req1_field;
  logic [1:0]    req1_mode;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_data;
  logic          resp_id;
  logic          busy;

  modport slave (
    input  req0_valid, req0_field, req0_mode,
    input  req1_valid, req1_field, req1_mode,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_data, resp_id, busy
  );

  modport master (
    output req0_valid, req0_field, req0_mode,
    output req1_valid, req1_field, req1_mode,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_data, resp_id, busy
  );

endinterface

// File: rtl/imm_ext_arbiter_core.sv
// Combinational immediate extender: sign- or zero-extends an 8- or 12-bit
// slice of the field to the result width according to the mode.
module imm_ext_core
  import imm_ext_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic [FW-1:0] i_field,
  input  logic [1:0]    i_mode,
  output logic [DW-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_mode)
      MODE_SEXT8:  o_result = {{(DW-8){i_field[7]}}, i_field[7:0]};
      MODE_SEXT12: o_result = {{(DW-FW){i_field[FW-1]}}, i_field};
      MODE_ZPAD8:  o_result = {{(DW-8){1'b0}}, i_field[7:0]};
      default:     o_result = {{(DW-FW){1'b0}}, i_field};
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between two requesters,
// returning tagged results over a registered valid/ready response channel.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic              clk,
  input  logic              reset,
  imm_ext_arbiter_if.slave  bus
);

  state_e        r_state;
  state_e        w_next;
  logic          r_last_grant;
  logic [FW-1:0] r_field;
  logic [1:0]    r_mode;
  logic          r_id;
  logic          r_resp_valid;
  logic [DW-1:0] r_resp_data;
  logic          r_resp_id;
  logic          w_gnt_id;
  logic          w_accept;
  logic [DW-1:0] w_ext;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    w_gnt_id       = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    w_accept       = (r_state == IDLE) && (bus.req0_valid || bus.req1_valid);
    bus.req0_ready = w_accept && !w_gnt_id;
    bus.req1_ready = w_accept && w_gnt_id;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = EXT;
      EXT:     w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_field <= w_gnt_id ? bus.req1_field : bus.req0_field;
      r_mode  <= w_gnt_id ? bus.req1_mode  : bus.req0_mode;
      r_id    <= w_gnt_id;
    end
  end

  imm_ext_core #(.DW(DW), .FW(FW)) u_core (
    .i_field  (r_field),
    .i_mode   (r_mode),
    .o_result (w_ext)
  );

  // The result register is cleared on reset so a discarded result never leaks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_gnt_id;
      if (r_state == EXT) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_ext;
        r_resp_id    <= r_id;
      end else if (r_state == RESP && bus.resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: doc/imm_ext_arbiter.md
Name: imm_ext_arbiter

Overview:
- Shared immediate-extension unit for the 16-bit multi-cycle processor.
- Two requesters submit a 12-bit immediate field and an extension mode:
  - requester 0: decode/operand path
  - requester 1: branch/jump target path
- One internal extender is time-shared between them using round-robin arbitration.
- Results are returned through a registered valid/ready response channel tagged with the requester ID.

Parameters:
- DW, 16, result width
- FW, 12, immediate field width (8-bit modes use field[7:0])

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_field  input  FW  requester 0 immediate field
- req0_mode  input  2  requester 0 extension mode
- req1_valid  input  1  requester 1 has a request
- req1_ready  output  1  requester 1 request accepted this cycle
- req1_field  input  FW  requester 1 immediate field
- req1_mode  input  2  requester 1 extension mode
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_data  output  DW  extended immediate
- resp_id  output  1  requester that owns resp_data
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock `clk`; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, resp_valid=0, resp_data=0, resp_id=0, busy=0
  - last_grant=1, so requester 0 wins the first contention
- Modes:
  - 00 SEXT8: {8{f[7]}, f[7:0]}
  - 01 SEXT12: {4{f[11]}, f[11:0]}
  - 10 ZPAD8: {8'h00, f[7:0]}
  - 11 ZPAD12: {4'h0, f[11:0]}
  - f[11:8] is ignored in the 8-bit modes.
- FSM states: IDLE, EXT, RESP.
- IDLE:
  - Grant is combinational from the valids:
    - only req0_valid → grant 0
    - only req1_valid → grant 1
    - both valid → grant !last_grant
  - reqN_ready=1 only for the granted requester, and only in IDLE.
  - On grant, capture field, mode and id into input registers, update last_grant, and go to EXT.
  - No valid → stay in IDLE.
- EXT:
  - Compute the extension from the captured registers.
  - Register the result into resp_data/resp_id, set resp_valid=1, and go to RESP.
- RESP:
  - Hold resp_valid, resp_data and resp_id stable until resp_ready=1.
  - On the resp_ready handshake: resp_valid=0 next cycle, state returns to IDLE.
  - Both req_ready outputs are 0 in EXT and RESP.
- Latency and throughput:
  - Accept at cycle N → resp_valid at N+2.
  - Minimum spacing between accepts is 3 cycles (no overlap).
- Handshake rules:
  - A request is accepted only when valid && ready.
  - Requesters must hold valid, field and mode until accepted.
  - Input changes while not accepted have no effect.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Reset during EXT or RESP: the in-flight result is discarded; all outputs return to reset values on the next edge.
- resp_ready while resp_valid=0 is ignored.

Decomposition:
- Shared package holds:
  - mode constants MODE_SEXT8=2'b00, MODE_SEXT12=2'b01, MODE_ZPAD8=2'b10, MODE_ZPAD12=2'b11
  - state encoding IDLE/EXT/RESP
  - DW/FW defaults
- One combinational sub-module, imm_ext_core (field, mode → result), instantiated once.
- Arbiter and FSM stay in the top module.

Test Plan:
- SEXT8 on requester 0: req0 field=12'h080, mode=00 → resp_data=16'hFF80, resp_id=0, resp_valid 2 cycles after accept.
- SEXT12 and ZPAD12 on requester 1:
  - req1 field=12'h800, mode=01 → 16'hF800, resp_id=1
  - then field=12'hFFF, mode=11 → 16'h0FFF
- ZPAD8 ignores the upper field bits: field=12'hFA5, mode=10 → 16'h00A5. The same field with mode=00 → 16'hFFA5.
- Contention and fairness: both valid continuously after reset for 4 transactions → resp_id sequence 0,1,0,1. req_ready is never high for both requesters in the same cycle, and never high outside IDLE.
- Backpressure: resp_ready held low for 3 cycles after resp_valid → resp_data and resp_id stable, no new accept. resp_ready=1 → resp_valid low on the next cycle and the next accept one cycle later.
- Reset mid-operation: assert reset during RESP with resp_data=16'hF800 → next cycle resp_valid=0, resp_data=0, busy=0. After release, contention grants requester 0 first.
